jtag_user_rsp: RTL and testbench

- Fabric-side JTAG responder. Follows the TAP protocol that the host/bench drives (TCK/TMS/TDI), decodes the 10-bit instruction register and implements the USER1 function register and the USER2 variable-length data register.
- Delivers decoded function codes and user-register payloads to jtagcom-style consumers as single-cycle strobes in the CLKCMS domain.
- Returns TDO for readback.
- TCK is oversampled; there is no TCK clock domain.

---
 rtl/jtag_user_rsp_if.sv | 35 +++
 rtl/jtag_user_rsp.sv | 244 ++++++++++++++++++++++++
 tb/tb_jtag_user_rsp.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_user_rsp_if.sv
// Pin bundle for the oversampled JTAG responder: TAP pins in,
// decoded function/user-register results out.
`timescale 1ns/1ps
interface jtag_user_rsp_if #(
  parameter int IR_WIDTH = 10,
  parameter int DR_WIDTH = 32
);
  logic                TCK;
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic                TAP_RST;
  logic [IR_WIDTH-1:0] IR;
  logic [7:0]          FUNC;
  logic                FUNC_STB;
  logic [DR_WIDTH-1:0] CAP_DATA;
  logic [DR_WIDTH-1:0] DR_OUT;
  logic [8:0]          DR_LEN;
  logic                DR_STB;

  modport master (
    output TCK, TMS, TDI, CAP_DATA,
    input  TDO, TDO_EN, TAP_RST, IR,
    input  FUNC, FUNC_STB,
    input  DR_OUT, DR_LEN, DR_STB
  );

  modport slave (
    input  TCK, TMS, TDI, CAP_DATA,
    output TDO, TDO_EN, TAP_RST, IR,
    output FUNC, FUNC_STB,
    output DR_OUT, DR_LEN, DR_STB
  );
endinterface

// File: rtl/jtag_user_rsp.sv
// Fabric-side JTAG responder: oversampled TAP, IR decode, USER1
// function register and USER2 variable-length data register.
`timescale 1ns/1ps
module jtag_user_rsp #(
  parameter int                  IR_WIDTH    = 10,
  parameter logic [IR_WIDTH-1:0] USER1_CODE  = 10'h3C2,
  parameter logic [IR_WIDTH-1:0] USER2_CODE  = 10'h3C3,
  parameter logic [IR_WIDTH-1:0] BYPASS_CODE = 10'h3FF,
  parameter int                  DR_WIDTH    = 32
) (
  input  logic CLKCMS,
  input  logic RST_N,
  jtag_user_rsp_if.slave bus
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR,
    PA_DR, EX2_DR, UP_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR,
    PA_IR, EX2_IR, UP_IR
  } tap_e;

  localparam logic [IR_WIDTH-1:0] IR_CAP =
    {{(IR_WIDTH-2){1'b0}}, 2'b01};
  localparam logic [8:0] DR_MAX = 9'(DR_WIDTH);

  logic [2:0] tck_q, tck_d;
  logic [1:0] tms_q, tms_d;
  logic [1:0] tdi_q, tdi_d;
  logic       tck_rise, tck_fall;
  logic       tms_s, tdi_s;

  tap_e state_q, state_d;

  logic sh_ir, sh_dr, cap_ir, cap_dr;
  logic tap_rst, go_up_ir, go_up_dr;
  logic sel_u1, sel_u2, act_lsb;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [7:0]          fn_sh_q, fn_sh_d;
  logic [DR_WIDTH-1:0] dr_sh_q, dr_sh_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                byp_q, byp_d;
  logic [7:0]          func_q, func_d;
  logic                func_stb_q, func_stb_d;
  logic [DR_WIDTH-1:0] dr_out_q, dr_out_d;
  logic [8:0]          dr_len_q, dr_len_d;
  logic                dr_stb_q, dr_stb_d;
  logic                tdo_q, tdo_d;

  // s1/s2 synchronize, s3 is history for edge detect
  always_comb begin
    tck_d = {tck_q[1:0], bus.TCK};
    tms_d = {tms_q[0], bus.TMS};
    tdi_d = {tdi_q[0], bus.TDI};
  end

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];

  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UP_DR  : PA_DR;
        PA_DR:   state_d = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  state_d = tms_s ? UP_DR  : SH_DR;
        UP_DR:   state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UP_IR  : PA_IR;
        PA_IR:   state_d = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  state_d = tms_s ? UP_IR  : SH_IR;
        UP_IR:   state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  always_comb begin
    tap_rst  = (state_q == TLR);
    sh_ir    = (state_q == SH_IR);
    sh_dr    = (state_q == SH_DR);
    cap_ir   = (state_q == CAP_IR);
    cap_dr   = (state_q == CAP_DR);
    go_up_ir = tck_rise & (state_d == UP_IR);
    go_up_dr = tck_rise & (state_d == UP_DR);
  end

  assign sel_u1 = (ir_q == USER1_CODE);
  assign sel_u2 = (ir_q == USER2_CODE);

  always_comb begin
    act_lsb = 1'b0;
    unique case (1'b1)
      sel_u1:  act_lsb = fn_sh_q[0];
      sel_u2:  act_lsb = dr_sh_q[0];
      default: act_lsb = byp_q;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    ir_sh_d    = ir_sh_q;
    fn_sh_d    = fn_sh_q;
    dr_sh_d    = dr_sh_q;
    cnt_d      = cnt_q;
    byp_d      = byp_q;
    func_d     = func_q;
    func_stb_d = 1'b0;
    dr_out_d   = dr_out_q;
    dr_len_d   = dr_len_q;
    dr_stb_d   = 1'b0;
    tdo_d      = tdo_q;

    if (tap_rst) begin
      ir_d = BYPASS_CODE;
    end

    if (tck_rise) begin
      if (cap_ir) begin
        ir_sh_d = IR_CAP;
      end
      if (sh_ir) begin
        ir_sh_d = {tdi_s, ir_sh_q[IR_WIDTH-1:1]};
      end
      if (go_up_ir) begin
        ir_d = ir_sh_q;
      end

      if (cap_dr) begin
        fn_sh_d = func_q;
        dr_sh_d = bus.CAP_DATA;
        cnt_d   = '0;
        byp_d   = 1'b0;
      end

      if (sh_dr) begin
        unique case (1'b1)
          sel_u1: begin
            fn_sh_d = {tdi_s, fn_sh_q[7:1]};
          end
          sel_u2: begin
            dr_sh_d = dr_sh_q >> 1;
            dr_sh_d[DR_WIDTH-1] = tdi_s;
            if (cnt_q != DR_MAX) begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          default: begin
            byp_d = tdi_s;
          end
        endcase
      end

      // payload sits in the top cnt bits; cnt==0 shifts everything out
      if (go_up_dr) begin
        if (sel_u1) begin
          func_d     = fn_sh_q;
          func_stb_d = 1'b1;
        end else if (sel_u2) begin
          dr_out_d = dr_sh_q >> (DR_MAX - cnt_q);
          dr_len_d = cnt_q;
          dr_stb_d = 1'b1;
        end
      end
    end

    if (tck_fall) begin
      if (sh_ir) begin
        tdo_d = ir_sh_q[0];
      end else if (sh_dr) begin
        tdo_d = act_lsb;
      end else begin
        tdo_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLKCMS or negedge RST_N) begin
    if (!RST_N) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      ir_q       <= BYPASS_CODE;
      ir_sh_q    <= '0;
      fn_sh_q    <= '0;
      dr_sh_q    <= '0;
      cnt_q      <= '0;
      byp_q      <= 1'b0;
      func_q     <= '0;
      func_stb_q <= 1'b0;
      dr_out_q   <= '0;
      dr_len_q   <= '0;
      dr_stb_q   <= 1'b0;
      tdo_q      <= 1'b0;
    end else begin
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      ir_q       <= ir_d;
      ir_sh_q    <= ir_sh_d;
      fn_sh_q    <= fn_sh_d;
      dr_sh_q    <= dr_sh_d;
      cnt_q      <= cnt_d;
      byp_q      <= byp_d;
      func_q     <= func_d;
      func_stb_q <= func_stb_d;
      dr_out_q   <= dr_out_d;
      dr_len_q   <= dr_len_d;
      dr_stb_q   <= dr_stb_d;
      tdo_q      <= tdo_d;
    end
  end

  assign bus.TDO      = tdo_q;
  assign bus.TDO_EN   = sh_ir | sh_dr;
  assign bus.TAP_RST  = tap_rst;
  assign bus.IR       = ir_q;
  assign bus.FUNC     = func_q;
  assign bus.FUNC_STB = func_stb_q;
  assign bus.DR_OUT   = dr_out_q;
  assign bus.DR_LEN   = dr_len_q;
  assign bus.DR_STB   = dr_stb_q;

endmodule

// File: tb/tb_jtag_user_rsp.sv
// Bench for jtag_user_rsp: vector table, random scans against a
// bit-stream model, and reset-during-scan sequence.
`timescale 1ns/1ps
module tb_jtag_user_rsp;
  localparam int IRW = 10;
  localparam int DRW = 32;
  localparam logic [9:0] U1  = 10'h3C2;
  localparam logic [9:0] U2  = 10'h3C3;
  localparam logic [9:0] BYP = 10'h3FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #12 clk = ~clk;

  jtag_user_rsp_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus ();

  jtag_user_rsp #(
    .IR_WIDTH(IRW), .USER1_CODE(U1), .USER2_CODE(U2),
    .BYPASS_CODE(BYP), .DR_WIDTH(DRW)
  ) dut (
    .CLKCMS(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int fstb_n = 0;
  int dstb_n = 0;
  int stb_err = 0;
  logic fprev = 1'b0;
  logic dprev = 1'b0;

  logic [7:0]  m_func;
  logic [31:0] m_dout;
  logic [8:0]  m_len;

  // strobe counting plus width / exclusivity watch
  always @(negedge clk) begin
    if (bus.FUNC_STB) fstb_n <= fstb_n + 1;
    if (bus.DR_STB) dstb_n <= dstb_n + 1;
    if ((bus.FUNC_STB && fprev) || (bus.DR_STB && dprev) ||
        (bus.FUNC_STB && bus.DR_STB))
      stb_err <= stb_err + 1;
    fprev <= bus.FUNC_STB;
    dprev <= bus.DR_STB;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tck_bit(input logic tms, input logic tdi,
                         output logic tdo);
    bus.TCK = 1'b0;
    bus.TMS = tms;
    bus.TDI = tdi;
    repeat (6) @(negedge clk);
    tdo = bus.TDO;
    bus.TCK = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic tms_seq(input logic [7:0] seq, input int n);
    logic t;
    for (int i = 0; i < n; i++) tck_bit(seq[i], 1'b0, t);
  endtask

  task automatic scan_ir(input logic [9:0] code,
                         output logic [63:0] tv);
    logic t;
    tv = '0;
    tms_seq(8'b0000_0011, 4);
    for (int i = 0; i < IRW; i++) begin
      tck_bit(i == IRW - 1, code[i], t);
      tv[i] = t;
    end
    tms_seq(8'b0000_0001, 2);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] data,
                         output logic [63:0] tv);
    logic t;
    tv = '0;
    tms_seq(8'b0000_0001, 2);
    if (n == 0) begin
      tck_bit(1'b1, 1'b0, t);
    end else begin
      tck_bit(1'b0, 1'b0, t);
      for (int i = 0; i < n; i++) begin
        tck_bit(i == n - 1, data[i], t);
        tv[i] = t;
      end
    end
    tms_seq(8'b0000_0001, 2);
  endtask

  // TDO is the old register contents followed by the TDI stream;
  // the register ends up holding the stream's next bits.
  task automatic run_scan(input logic [9:0] ir, input int n,
                          input logic [63:0] data,
                          input logic [31:0] cap,
                          input string tag);
    logic [63:0] tv, texp, mask, reg_v;
    bit s[$];
    int f0, d0, L, k;
    bus.CAP_DATA = cap;
    scan_ir(ir, tv);
    chk({tag, ".ir"}, 64'(bus.IR), 64'(ir));
    chk({tag, ".ir_tdo"}, tv, 64'h001);
    chk({tag, ".func_keep"}, 64'(bus.FUNC), 64'(m_func));
    chk({tag, ".dout_keep"}, 64'(bus.DR_OUT), 64'(m_dout));
    f0 = fstb_n;
    d0 = dstb_n;
    scan_dr(n, data, tv);
    if (ir == U1) begin
      L = 8; reg_v = 64'(m_func);
    end else if (ir == U2) begin
      L = DRW; reg_v = 64'(cap);
    end else begin
      L = 1; reg_v = '0;
    end
    for (int i = 0; i < L; i++) s.push_back(reg_v[i]);
    for (int i = 0; i < n; i++) s.push_back(data[i]);
    texp = '0;
    for (int j = 0; j < n; j++) texp[j] = s[j];
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (ir == U1) begin
      for (int i = 0; i < 8; i++) m_func[i] = s[n + i];
    end
    if (ir == U2) begin
      k = (n < DRW) ? n : DRW;
      m_dout = '0;
      for (int i = 0; i < k; i++) m_dout[i] = data[n - k + i];
      m_len = 9'(k);
    end
    chk({tag, ".tdo"}, tv & mask, texp);
    chk({tag, ".func"}, 64'(bus.FUNC), 64'(m_func));
    chk({tag, ".dout"}, 64'(bus.DR_OUT), 64'(m_dout));
    chk({tag, ".len"}, 64'(bus.DR_LEN), 64'(m_len));
    chk({tag, ".fstb"}, 64'(fstb_n - f0), 64'(ir == U1));
    chk({tag, ".dstb"}, 64'(dstb_n - d0), 64'(ir == U2));
  endtask

  typedef struct {
    logic [9:0]  ir;
    int          n;
    logic [63:0] data;
    logic [31:0] cap;
    logic [7:0]  func;
    logic [31:0] dout;
    logic [8:0]  len;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [63:0] tv;
    logic [9:0]  rir;
    int          f0, d0;

    tbl[0] = '{U1,   8, 64'h02,          32'h0,         8'h02, 32'h0,        9'd0};
    tbl[1] = '{U2,  19, 64'h7B5B8,       32'hFFFF_FFFF, 8'h02, 32'h0007B5B8, 9'd19};
    tbl[2] = '{U2,  18, 64'h36000,       32'h1357_9BDF, 8'h02, 32'h00036000, 9'd18};
    tbl[3] = '{U2,  32, 64'h0,           32'hA5A5_1234, 8'h02, 32'h0,        9'd32};
    tbl[4] = '{U2,  40, 64'hAB_CDEF_0123, 32'h0,        8'h02, 32'hABCDEF01, 9'd32};
    tbl[5] = '{BYP,  4, 64'hD,           32'h0,         8'h02, 32'hABCDEF01, 9'd32};
    tbl[6] = '{U2,   0, 64'h0,           32'hDEAD_BEEF, 8'h02, 32'h0,        9'd0};
    tbl[7] = '{U1,   8, 64'h9C,          32'h0,         8'h9C, 32'h0,        9'd0};
    tbl[8] = '{U1,  12, 64'hABC,         32'h0,         8'hAB, 32'h0,        9'd0};

    bus.TCK = 1'b0;
    bus.TMS = 1'b1;
    bus.TDI = 1'b0;
    bus.CAP_DATA = '0;
    m_func = '0;
    m_dout = '0;
    m_len = '0;
    repeat (5) @(negedge clk);
    chk("rst.tap_rst", 64'(bus.TAP_RST), 64'd1);
    chk("rst.ir", 64'(bus.IR), 64'(BYP));
    chk("rst.func", 64'(bus.FUNC), 64'd0);
    chk("rst.dout", 64'(bus.DR_OUT), 64'd0);
    chk("rst.len", 64'(bus.DR_LEN), 64'd0);
    chk("rst.tdo", {62'd0, bus.TDO, bus.TDO_EN}, 64'd0);
    chk("rst.stb", {62'd0, bus.FUNC_STB, bus.DR_STB}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    tms_seq(8'b0001_1111, 5);
    chk("tlr.tap_rst", 64'(bus.TAP_RST), 64'd1);
    tms_seq(8'b0000_0000, 1);
    chk("rti.tap_rst", 64'(bus.TAP_RST), 64'd0);
    chk("rti.ir", 64'(bus.IR), 64'(BYP));

    for (int i = 0; i < 9; i++) begin
      run_scan(tbl[i].ir, tbl[i].n, tbl[i].data, tbl[i].cap,
               $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tfunc", i), 64'(bus.FUNC), 64'(tbl[i].func));
      chk($sformatf("vec%0d.tdout", i), 64'(bus.DR_OUT), 64'(tbl[i].dout));
      chk($sformatf("vec%0d.tlen", i), 64'(bus.DR_LEN), 64'(tbl[i].len));
    end

    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: rir = U1;
        1: rir = U2;
        2: rir = BYP;
        default: rir = 10'($urandom);
      endcase
      run_scan(rir, $urandom_range(0, 45),
               {$urandom, $urandom}, $urandom,
               $sformatf("rnd%0d", r));
    end

    run_scan(U1, 8, 64'hC3, 32'h0, "pre_rst");
    scan_ir(U2, tv);
    tms_seq(8'b0000_0001, 3);
    for (int i = 0; i < 9; i++) tck_bit(1'b0, 1'($urandom), tv[0]);
    chk("mid.tdo_en", 64'(bus.TDO_EN), 64'd1);
    d0 = dstb_n;
    f0 = fstb_n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.ir", 64'(bus.IR), 64'(BYP));
    chk("mid.func", 64'(bus.FUNC), 64'd0);
    chk("mid.dout", 64'(bus.DR_OUT), 64'd0);
    chk("mid.len", 64'(bus.DR_LEN), 64'd0);
    chk("mid.pins", {61'd0, bus.TDO, bus.TDO_EN, bus.TAP_RST}, 64'd1);
    bus.TCK = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid.nostb", 64'((dstb_n - d0) + (fstb_n - f0)), 64'd0);
    m_func = '0;
    m_dout = '0;
    m_len = '0;
    tms_seq(8'b0000_0000, 1);
    run_scan(U1, 8, 64'h5A, 32'h0, "post_rst");
    chk("post_rst.func5a", 64'(bus.FUNC), 64'h5A);
    chk("post_rst.len", 64'(bus.DR_LEN), 64'd0);

    repeat (4) @(negedge clk);
    chk("stb_pulse", 64'(stb_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
